// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state enum, STATE encodings and default parameters for seq_detector
package seq_det_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_FILL = 2'd1;
  localparam logic [1:0] STATE_HUNT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    FILL = STATE_FILL,
    HUNT = STATE_HUNT
  } seq_state_e;

  localparam int DEF_SYM_W = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_window.sv
// rtl/seq_window.sv - history shift register (index 0 oldest) with saturating fill counter
module seq_window #(
  parameter int SYM_W  = 4,
  parameter int DEPTH  = 4,
  parameter int FILL_W = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        shift_i,
  input  logic                        flush_i,
  input  logic [SYM_W-1:0]            sym_i,
  output logic [DEPTH-1:0][SYM_W-1:0] window_o,
  output logic [FILL_W-1:0]           fill_o
);

  logic [DEPTH-1:0][SYM_W-1:0] window_q, window_d;
  logic [FILL_W-1:0]           fill_q, fill_d;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (shift_i) begin
      for (int i = 0; i < DEPTH - 1; i++) window_d[i] = window_q[i+1];
      window_d[DEPTH-1] = sym_i;
      if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + 1'b1;
    end
    // Flushing only forgets progress; stale window contents are masked by fill.
    if (flush_i) fill_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

  assign window_o = window_q;
  assign fill_o   = fill_q;

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - programmable sequence detector: FSM, pattern compare, saturating match counter
// Optional per-bit don't-care masks when SEQDET_MASK_EN is defined.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int SYM_W = DEF_SYM_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     OVERLAP,
  input  logic                     LOAD,
  input  logic [$clog2(DEPTH)-1:0] LOAD_IDX,
  input  logic [SYM_W-1:0]         LOAD_SYM,
`ifdef SEQDET_MASK_EN
  input  logic [SYM_W-1:0]         LOAD_MASK,
`endif
  input  logic                     VALID,
  input  logic [SYM_W-1:0]         SYM,
  input  logic                     CLR_CNT,
  output logic                     MATCH,
  output logic [CNT_W-1:0]         COUNT,
  output logic [1:0]               STATE
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  seq_state_e                  state_q, state_d;
  logic [DEPTH-1:0][SYM_W-1:0] pat_q, pat_d;
  logic [DEPTH-1:0][SYM_W-1:0] care;
  logic [DEPTH-1:0][SYM_W-1:0] window, win_next;
  logic [FILL_W-1:0]           fill;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        match_q;
  logic                        accept, full_next, eq, hit, flush, slot_ok;

  assign accept    = VALID & EN & ~LOAD;
  assign full_next = fill >= FILL_W'(DEPTH - 1);
  assign slot_ok   = int'(LOAD_IDX) < DEPTH;

  seq_window #(.SYM_W(SYM_W), .DEPTH(DEPTH), .FILL_W(FILL_W)) u_window (
    .CLK      (CLK),
    .RST      (RST),
    .shift_i  (accept),
    .flush_i  (flush),
    .sym_i    (SYM),
    .window_o (window),
    .fill_o   (fill)
  );

`ifdef SEQDET_MASK_EN
  logic [DEPTH-1:0][SYM_W-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (LOAD && slot_ok) mask_d[LOAD_IDX] = LOAD_MASK;
  end

  always_ff @(posedge CLK) begin
    if (RST) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign care = ~mask_q;
`else
  assign care = '1;
`endif

  // Compare against the window as it will look once the incoming symbol is shifted in.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) win_next[i] = window[i+1];
    win_next[DEPTH-1] = SYM;
    eq = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (((win_next[i] ^ pat_q[i]) & care[i]) != '0) eq = 1'b0;
    end
  end

  assign hit   = accept & full_next & eq;
  assign flush = ~EN | LOAD | (hit & ~OVERLAP);

  always_comb begin
    pat_d = pat_q;
    if (LOAD && slot_ok) pat_d[LOAD_IDX] = LOAD_SYM;
  end

  always_comb begin
    state_d = state_q;
    if (!EN) begin
      state_d = IDLE;
    end else if (LOAD) begin
      state_d = FILL;
    end else begin
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: if (accept && full_next) state_d = (hit && !OVERLAP) ? FILL : HUNT;
        HUNT: if (hit && !OVERLAP) state_d = FILL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (CLR_CNT)                      count_d = '0;
    else if (hit && (count_q != '1))  count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pat_q   <= '0;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      count_q <= count_d;
      match_q <= hit;
    end
  end

  assign MATCH = match_q;
  assign COUNT = count_q;
  assign STATE = state_q;

endmodule
